// File: rtl/secure_key_vault_if.sv
// secure_key_vault_if: load, key-use and debug-readback channels of the key vault.
`timescale 1ns/1ps
interface secure_key_vault_if #(
    parameter int KEY_W     = 128,
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_AW = $clog2(NUM_SLOTS);

    logic               load_valid;
    logic [SLOT_AW-1:0] load_slot;
    logic [KEY_W-1:0]   load_key;
    logic               load_ready;

    logic [SLOT_AW-1:0] use_slot;
    logic [KEY_W-1:0]   key_out;
    logic               key_valid;

    logic               debug_mode;
    logic               debug_ack;
    logic               dbg_rd_en;
    logic [SLOT_AW-1:0] dbg_rd_slot;
    logic [KEY_W-1:0]   debug_output;
    logic               dbg_rd_valid;

    modport master (
        output load_valid, load_slot, load_key, use_slot,
               debug_mode, dbg_rd_en, dbg_rd_slot,
        input  load_ready, key_out, key_valid, debug_ack,
               debug_output, dbg_rd_valid
    );

    modport slave (
        input  load_valid, load_slot, load_key, use_slot,
               debug_mode, dbg_rd_en, dbg_rd_slot,
        output load_ready, key_out, key_valid, debug_ack,
               debug_output, dbg_rd_valid
    );
endinterface

// File: rtl/secure_key_vault.sv
// secure_key_vault: multi-slot key store that zeroizes every slot before granting debug access.
// Defining VAULT_DEBUG_LOCK_EN adds a sticky lock_set/locked pair that blocks debug entry.
`timescale 1ns/1ps
module secure_key_vault #(
    parameter int KEY_W     = 128,
    parameter int NUM_SLOTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    secure_key_vault_if.slave bus
`ifdef VAULT_DEBUG_LOCK_EN
    ,
    input  logic              lock_set,
    output logic              locked
`endif
);
    localparam int                 SLOT_AW   = $clog2(NUM_SLOTS);
    localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {SECURE, ZEROIZE, DEBUG, EXIT} state_t;

    state_t               state;
    state_t               next_state;
    logic [KEY_W-1:0]     slots [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] zeroized;
    logic [SLOT_AW-1:0]   zero_cnt;
    logic [KEY_W-1:0]     debug_data;
    logic                 rd_valid;
    logic                 debug_req;
    logic                 load_ready;
    logic                 zero_we;
    logic                 load_we;

`ifdef VAULT_DEBUG_LOCK_EN
    // The lock only gates entry from SECURE, so a session already under way completes normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (lock_set) begin
            locked <= 1'b1;
        end
    end

    assign debug_req = bus.debug_mode && !locked;
`else
    assign debug_req = bus.debug_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SECURE;
        end else begin
            state <= next_state;
        end
    end

    // A load coinciding with a debug request is refused so nothing lands after zeroize starts.
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        zero_we    = 1'b0;
        case (state)
            SECURE: begin
                load_ready = !debug_req;
                if (debug_req) begin
                    next_state = ZEROIZE;
                end
            end
            ZEROIZE: begin
                zero_we = 1'b1;
                if (zero_cnt == LAST_SLOT) begin
                    next_state = DEBUG;
                end
            end
            DEBUG: begin
                if (!bus.debug_mode) begin
                    next_state = EXIT;
                end
            end
            EXIT: begin
                next_state = SECURE;
            end
            default: begin
                next_state = SECURE;
            end
        endcase
    end

    assign load_we = bus.load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            slot_valid <= '0;
            zeroized   <= '0;
            zero_cnt   <= '0;
        end else begin
            if (load_we) begin
                slots[bus.load_slot]      <= bus.load_key;
                slot_valid[bus.load_slot] <= 1'b1;
            end
            if (zero_we) begin
                slots[zero_cnt]      <= '0;
                slot_valid[zero_cnt] <= 1'b0;
                zeroized[zero_cnt]   <= 1'b1;
                zero_cnt             <= zero_cnt + SLOT_AW'(1);
            end
            if (state == EXIT) begin
                zeroized <= '0;
            end
        end
    end

    // Readback is masked by the per-session zeroized bit so no live key can ever leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_data <= '0;
            rd_valid   <= 1'b0;
        end else if (state == DEBUG) begin
            rd_valid <= bus.dbg_rd_en;
            if (bus.dbg_rd_en) begin
                debug_data <= zeroized[bus.dbg_rd_slot] ? slots[bus.dbg_rd_slot] : '0;
            end
        end else begin
            debug_data <= '0;
            rd_valid   <= 1'b0;
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.key_out      = (state == SECURE) ? slots[bus.use_slot] : '0;
    assign bus.key_valid    = (state == SECURE) && slot_valid[bus.use_slot];
    assign bus.debug_ack    = (state == DEBUG);
    assign bus.debug_output = debug_data;
    assign bus.dbg_rd_valid = rd_valid;
endmodule

// File: tb/tb_secure_key_vault.sv
// tb_secure_key_vault: directed and randomized checks of secure_key_vault against a behavioural model.
`timescale 1ns/1ps
module tb_secure_key_vault;
    localparam int KEY_W     = 128;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_AW   = $clog2(NUM_SLOTS);

    typedef enum {PH_SECURE, PH_ZEROIZE, PH_DEBUG, PH_EXIT} phase_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef VAULT_DEBUG_LOCK_EN
    logic lock_set = 1'b0;
    logic locked;
`endif

    secure_key_vault_if #(.KEY_W(KEY_W), .NUM_SLOTS(NUM_SLOTS)) bus ();

    secure_key_vault #(.KEY_W(KEY_W), .NUM_SLOTS(NUM_SLOTS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef VAULT_DEBUG_LOCK_EN
        ,
        .lock_set (lock_set),
        .locked   (locked)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    phase_t           m_ph = PH_SECURE;
    logic [KEY_W-1:0] m_key [NUM_SLOTS];
    bit               m_valid [NUM_SLOTS];
    int               m_zidx = 0;
    bit               m_rdv = 1'b0;
    logic [KEY_W-1:0] m_dout = '0;
    bit               m_locked = 1'b0;

    task automatic checkOutput(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEY_W; i += 32) begin
            k = (k << 32) | KEY_W'($urandom);
        end
        return k;
    endfunction

    function automatic bit model_req();
`ifdef VAULT_DEBUG_LOCK_EN
        return bus.debug_mode && !m_locked;
`else
        return bus.debug_mode;
`endif
    endfunction

    task automatic model_reset();
        m_ph     = PH_SECURE;
        m_zidx   = 0;
        m_rdv    = 1'b0;
        m_dout   = '0;
        m_locked = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_key[i]   = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    // Vault rules: loads only while secure and not entering debug, NUM_SLOTS wipe cycles, one-cycle exit.
    task automatic model_step();
        bit     req;
        phase_t was;
        req = model_req();
        was = m_ph;
`ifdef VAULT_DEBUG_LOCK_EN
        if (lock_set) m_locked = 1'b1;
`endif
        m_rdv = 1'b0;
        case (was)
            PH_SECURE: begin
                if (req) begin
                    m_ph   = PH_ZEROIZE;
                    m_zidx = 0;
                end else if (bus.load_valid) begin
                    m_key[int'(bus.load_slot)]   = bus.load_key;
                    m_valid[int'(bus.load_slot)] = 1'b1;
                end
            end
            PH_ZEROIZE: begin
                m_key[m_zidx]   = '0;
                m_valid[m_zidx] = 1'b0;
                m_zidx++;
                if (m_zidx == NUM_SLOTS) m_ph = PH_DEBUG;
            end
            PH_DEBUG: begin
                if (bus.dbg_rd_en) begin
                    m_rdv  = 1'b1;
                    m_dout = m_key[int'(bus.dbg_rd_slot)];
                end
                if (!bus.debug_mode) m_ph = PH_EXIT;
            end
            default: m_ph = PH_SECURE;
        endcase
        if (was != PH_DEBUG) m_dout = '0;
    endtask

    task automatic compare_all();
        bit secure;
        int us;
        secure = (m_ph == PH_SECURE);
        us     = int'(bus.use_slot);
        checkOutput("load_ready", KEY_W'(bus.load_ready), KEY_W'(secure && !model_req()));
        checkOutput("key_out", bus.key_out, secure ? m_key[us] : '0);
        checkOutput("key_valid", KEY_W'(bus.key_valid), KEY_W'(secure && m_valid[us]));
        checkOutput("debug_ack", KEY_W'(bus.debug_ack), KEY_W'(m_ph == PH_DEBUG));
        checkOutput("dbg_rd_valid", KEY_W'(bus.dbg_rd_valid), KEY_W'(m_rdv));
        checkOutput("debug_output", bus.debug_output, m_dout);
`ifdef VAULT_DEBUG_LOCK_EN
        checkOutput("locked", KEY_W'(locked), KEY_W'(m_locked));
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (check_en) compare_all();
    end

    task automatic applyStimulus(input bit lv, input int ls, input logic [KEY_W-1:0] lk,
                                 input int us, input bit dm, input bit re, input int rs);
        @(posedge clk);
        #1;
        bus.load_valid  = lv;
        bus.load_slot   = SLOT_AW'(ls);
        bus.load_key    = lk;
        bus.use_slot    = SLOT_AW'(us);
        bus.debug_mode  = dm;
        bus.dbg_rd_en   = re;
        bus.dbg_rd_slot = SLOT_AW'(rs);
    endtask

    initial begin
        logic [KEY_W-1:0] a5;
        logic [KEY_W-1:0] k;
        int cnt;
        int acks;
        bit dm_r;

        a5 = {16{8'hA5}};
        bus.load_valid  = 1'b0;
        bus.load_slot   = '0;
        bus.load_key    = '0;
        bus.use_slot    = '0;
        bus.debug_mode  = 1'b0;
        bus.dbg_rd_en   = 1'b0;
        bus.dbg_rd_slot = '0;
        model_reset();

        #12;
        checkOutput("reset_key_out", bus.key_out, '0);
        checkOutput("reset_debug_ack", KEY_W'(bus.debug_ack), '0);
        checkOutput("reset_rd_valid", KEY_W'(bus.dbg_rd_valid), '0);
        #10 rst_n = 1'b1;
        check_en = 1'b1;

        // Single load then use.
        applyStimulus(1, 2, a5, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 2, 0, 0, 0);
        @(negedge clk);
        checkOutput("load_key_out", bus.key_out, a5);
        checkOutput("load_key_valid", KEY_W'(bus.key_valid), KEY_W'(1));

        // Full debug session: ack latency and zero readback.
        for (int s = 0; s < NUM_SLOTS; s++) applyStimulus(1, s, rand_key(), s, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("zeroize_load_ready", KEY_W'(bus.load_ready), '0);
        checkOutput("zeroize_key_valid", KEY_W'(bus.key_valid), '0);
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk);
            cnt++;
            #1;
            if (bus.debug_ack) break;
        end
        checkOutput("ack_latency", KEY_W'(cnt), KEY_W'(4));
        for (int s = 0; s < NUM_SLOTS; s++) begin
            applyStimulus(0, 0, '0, 0, 1, 1, s);
            applyStimulus(0, 0, '0, 0, 1, 0, 0);
            @(negedge clk);
            checkOutput("readback_valid", KEY_W'(bus.dbg_rd_valid), KEY_W'(1));
            checkOutput("readback_data", bus.debug_output, '0);
        end
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("exit_debug_ack", KEY_W'(bus.debug_ack), '0);
        checkOutput("exit_load_ready", KEY_W'(bus.load_ready), '0);
        for (int s = 0; s < NUM_SLOTS; s++) begin
            applyStimulus(0, 0, '0, s, 0, 0, 0);
            @(negedge clk);
            checkOutput("after_session_valid", KEY_W'(bus.key_valid), '0);
        end

        // Debug request dropped after two wipe cycles.
        for (int s = 0; s < NUM_SLOTS; s++) applyStimulus(1, s, rand_key(), s, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        cnt  = 0;
        acks = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (bus.debug_ack) acks++;
            if (bus.load_ready) break;
        end
        checkOutput("drop_cycles_to_secure", KEY_W'(cnt), KEY_W'(4));
        checkOutput("drop_debug_cycles", KEY_W'(acks), KEY_W'(1));
        for (int s = 0; s < NUM_SLOTS; s++) begin
            applyStimulus(0, 0, '0, s, 0, 0, 0);
            @(negedge clk);
            checkOutput("drop_key_valid", KEY_W'(bus.key_valid), '0);
        end

        // Load and debug request in the same cycle.
        applyStimulus(1, 3, rand_key(), 3, 1, 0, 0);
        @(negedge clk);
        checkOutput("collide_load_ready", KEY_W'(bus.load_ready), '0);
        cnt = 0;
        do begin
            applyStimulus(0, 0, '0, 3, 1, 0, 0);
            @(negedge clk);
            cnt++;
        end while (!bus.debug_ack && cnt < 20);
        checkOutput("collide_reach_debug", KEY_W'(bus.debug_ack), KEY_W'(1));
        applyStimulus(0, 0, '0, 3, 0, 0, 0);
        applyStimulus(0, 0, '0, 3, 0, 0, 0);
        applyStimulus(0, 0, '0, 3, 0, 0, 0);
        @(negedge clk);
        checkOutput("collide_key_valid", KEY_W'(bus.key_valid), '0);
        checkOutput("collide_key_out", bus.key_out, '0);

        // Asynchronous reset in the middle of a debug session.
        cnt = 0;
        do begin
            applyStimulus(0, 0, '0, 0, 1, 0, 0);
            @(negedge clk);
            cnt++;
        end while (!bus.debug_ack && cnt < 20);
        applyStimulus(0, 0, '0, 0, 1, 1, 1);
        applyStimulus(0, 0, '0, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        k = rand_key();
        rst_n          = 1'b0;
        bus.debug_mode = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_slot  = '0;
        bus.load_key   = k;
        #1;
        checkOutput("async_debug_ack", KEY_W'(bus.debug_ack), '0);
        checkOutput("async_rd_valid", KEY_W'(bus.dbg_rd_valid), '0);
        checkOutput("async_debug_output", bus.debug_output, '0);
        checkOutput("async_key_valid", KEY_W'(bus.key_valid), '0);
        checkOutput("async_key_out", bus.key_out, '0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("first_edge_load_key", bus.key_out, k);
        checkOutput("first_edge_load_valid", KEY_W'(bus.key_valid), KEY_W'(1));

        // Randomized traffic with one mid-cycle reset pulse.
        dm_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (dm_r) dm_r = ($urandom_range(0, 9) != 0);
            else      dm_r = ($urandom_range(0, 24) == 0);
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_SLOTS - 1)), rand_key(),
                          int'($urandom_range(0, NUM_SLOTS - 1)), dm_r, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, NUM_SLOTS - 1)));
            if (i == 300) begin
                #3 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

`ifdef VAULT_DEBUG_LOCK_EN
        // Lock blocks debug entry entirely.
        @(negedge clk);
        rst_n = 1'b0;
        bus.debug_mode = 1'b0;
        #2 rst_n = 1'b1;
        k = rand_key();
        applyStimulus(1, 1, k, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0, 0);
        lock_set = 1'b1;
        applyStimulus(0, 0, '0, 1, 0, 0, 0);
        lock_set = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, '0, 1, 1, 0, 0);
            @(negedge clk);
            checkOutput("lock_debug_ack", KEY_W'(bus.debug_ack), '0);
            checkOutput("lock_key_out", bus.key_out, k);
        end
        checkOutput("lock_locked", KEY_W'(locked), KEY_W'(1));
`endif

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
